axis_deadlock_monitor: RTL

Parametrised successor to the per-kernel deadlock monitor used in HLS co-simulation tops. It watches N AXIS port block flags and M instance idle/block flags, and declares a kernel block only after a programmable number of consecutive stalled cycles. On detection it captures a snapshot of which ports and instances were blocked, and counts block events. It offers sticky and self-clearing modes, and is instantiated once per kernel inside the kernel monitor top, replacing the fixed-size idx0 monitor.

---
 rtl/axis_deadlock_pkg.sv | 17 +
 rtl/deadlock_sat_counter.sv | 22 ++
 rtl/axis_deadlock_monitor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/axis_deadlock_pkg.sv
// Shared types and helpers for the AXIS kernel deadlock monitor.
package axis_deadlock_pkg;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } dl_state_e;

    // Increment v, holding at the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/deadlock_sat_counter.sv
// Saturating up-counter with synchronous clear; backs both the stall
// count and the block event count.
module deadlock_sat_counter
    import axis_deadlock_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (inc)
            cnt <= W'(sat_inc(32'(cnt), W));
    end

endmodule

// File: rtl/axis_deadlock_monitor.sv
// Per-kernel deadlock monitor: declares a block after timeout_cycles
// consecutive stall cycles and snapshots the blocked ports/instances.
module axis_deadlock_monitor
    import axis_deadlock_pkg::*;
#(
    parameter int N_AXIS = 2,
    parameter int N_INST = 2,
    parameter int CNT_W  = 16,
    parameter int EVT_W  = 8,
    parameter int STICKY = 1
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [CNT_W-1:0]  timeout_cycles,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    output logic              block,
    output logic              block_pulse,
    output logic [N_AXIS-1:0] block_port_snap,
    output logic [N_INST-1:0] block_inst_snap,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [EVT_W-1:0]  block_events
);

    dl_state_e        state, state_n;
    logic             stall_cond;
    logic [CNT_W:0]   stall_cnt_p1;
    logic             block_n, pulse_n;
    logic             cnt_clr, cnt_inc;
    logic             evt_clr, evt_inc;
    logic             snap_clr, snap_load;

    assign stall_cond   = (|axis_block_sigs) && (&(inst_idle_sigs | inst_block_sigs));
    // One bit wider so the threshold compare still works at saturation.
    assign stall_cnt_p1 = {1'b0, stall_cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_n   = state;
        block_n   = block;
        pulse_n   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        evt_clr   = 1'b0;
        evt_inc   = 1'b0;
        snap_clr  = 1'b0;
        snap_load = 1'b0;
        if (clear) begin
            state_n  = MONITOR;
            block_n  = 1'b0;
            cnt_clr  = 1'b0 | 1'b1;
            evt_clr  = 1'b1;
            snap_clr = 1'b1;
        end else if (!enable) begin
            state_n = MONITOR;
            block_n = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state)
                MONITOR: begin
                    if (stall_cond && timeout_cycles != '0) begin
                        cnt_inc = 1'b1;
                        if (timeout_cycles == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_n   = BLOCKED;
                            block_n   = 1'b1;
                            pulse_n   = 1'b1;
                            snap_load = 1'b1;
                            evt_inc   = 1'b1;
                        end else begin
                            state_n = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (!stall_cond || timeout_cycles == '0) begin
                        state_n = MONITOR;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                        if (stall_cnt_p1 >= {1'b0, timeout_cycles}) begin
                            state_n   = BLOCKED;
                            block_n   = 1'b1;
                            pulse_n   = 1'b1;
                            snap_load = 1'b1;
                            evt_inc   = 1'b1;
                        end
                    end
                end
                BLOCKED: begin
                    if (STICKY == 0 && !stall_cond) begin
                        state_n = MONITOR;
                        block_n = 1'b0;
                        cnt_clr = 1'b1;
                    end
                end
                default: begin
                    state_n = MONITOR;
                    block_n = 1'b0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge kernel_monitor_clock) begin
        if (!kernel_monitor_reset) begin
            state           <= MONITOR;
            block           <= 1'b0;
            block_pulse     <= 1'b0;
            block_port_snap <= '0;
            block_inst_snap <= '0;
        end else begin
            state       <= state_n;
            block       <= block_n;
            block_pulse <= pulse_n;
            if (snap_clr) begin
                block_port_snap <= '0;
                block_inst_snap <= '0;
            end else if (snap_load) begin
                block_port_snap <= axis_block_sigs;
                block_inst_snap <= inst_block_sigs;
            end
        end
    end

    deadlock_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (kernel_monitor_clock),
        .rst_n (kernel_monitor_reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (stall_cnt)
    );

    deadlock_sat_counter #(.W(EVT_W)) u_evt_cnt (
        .clk   (kernel_monitor_clock),
        .rst_n (kernel_monitor_reset),
        .clr   (evt_clr),
        .inc   (evt_inc),
        .cnt   (block_events)
    );

endmodule
